weight_pingpong_buff: RTL and testbench
=======================================

// Module: weight_pingpong_buff
// PURPOSE
//  Double-banked (ping-pong) weight buffer between the weight loader and the PE array.
//  A new kernel loads into the shadow bank while the active bank streams to the PEs.
//  Streaming can repeat the kernel N times, once per output pixel.
//  Swaps are deferred until the reader is idle; the PE never sees a half-written kernel.
// PARAMETERS
//  DATA_WIDTH    16  weight word width
//  BUFFER_DEPTH  16  words per bank; max kernel_size; power of two, <=256
//  PTR_W    $clog2(BUFFER_DEPTH)  derived localparam, not overridable
// PORTS
//  clk          in   1           single clock for load and read sides
//  rst          in   1           synchronous reset, active-high
//  kernel_size  in   8           weights per kernel; sampled at load_start
//  load_start   in   1           begin filling the shadow bank
//  wr_valid     in   1           write beat valid
//  wr_data      in   DATA_WIDTH  write beat data
//  wr_ready     out  1           shadow bank accepting beats
//  load_done    out  1           1-cycle pulse when the swap commits
//  cfg_err      out  1           sticky: last kernel_size was 0 or >BUFFER_DEPTH
//  kernel_busy  out  1           load in progress, or shadow full awaiting swap
//  un_configed  out  1           no kernel committed since reset
//  rd_start     in   1           begin streaming the active kernel
//  rd_repeat    in   8           passes over the kernel; sampled at rd_start; 0 treated as 1
//  rd_stall     in   1           hold read pointer and outputs
//  data_out     out  DATA_WIDTH  weight; 0 when out_valid=0
//  out_valid    out  1           data_out valid this cycle
//  out_last     out  1           last word of the last pass
//  read_busy    out  1           read FSM in R_RUN
// BEHAVIOUR
//  Reset (rst=1 at posedge): all FSMs idle, pointers and counters 0, active_bank=0.
//   Outputs: wr_ready=0, load_done=0, cfg_err=0, kernel_busy=0, un_configed=1,
//   data_out=0, out_valid=0, out_last=0, read_busy=0. Bank RAM is not cleared.
//  Reset mid-load or mid-read abandons the operation; un_configed returns to 1.
//  Write FSM W_IDLE -> W_LOAD -> W_FULL -> W_IDLE.
//   W_IDLE: load_start=1 -> W_LOAD, wr_ptr=0, latch size.
//    Size 0 -> 1; size >DEPTH -> DEPTH. cfg_err set on either clamp.
//   W_LOAD: wr_ready=1. Beat accepted when wr_valid&&wr_ready; it writes
//    shadow[wr_ptr] and increments wr_ptr. After beat number size -> W_FULL.
//    load_start is ignored here.
//   W_FULL: wr_ready=0. Swap when read FSM is R_IDLE: toggle active_bank,
//    active_size<=shadow_size, un_configed<=0, load_done=1 for one cycle -> W_IDLE.
//   kernel_busy = (state != W_IDLE).
//  Read FSM R_IDLE <-> R_RUN.
//   R_IDLE: rd_start=1 && (un_configed=0 || swap this cycle) -> R_RUN,
//    rd_ptr=0, pass_cnt=0. Otherwise rd_start is ignored.
//   Swap and rd_start in the same cycle: the stream reads the NEW bank.
//   R_RUN: data_out = bank[active_bank][rd_ptr], combinational from registers.
//    out_valid = !rd_stall. Latency: first word 1 cycle after rd_start.
//    Each non-stalled cycle: rd_ptr++. At rd_ptr==active_size-1: rd_ptr wraps to 0, pass_cnt++.
//    Final word of pass rd_repeat: out_last=1, then -> R_IDLE.
//   rd_start in R_RUN is ignored. rd_stall holds all read state.
//   Writes never target the active bank, so a concurrent load cannot corrupt the stream.
//  Widths: size latches are PTR_W+1 bits. pass_cnt is 8 bits. No other arithmetic.
// STRUCTURE
//  Shared header weight_buff_defs.vh: W_IDLE/W_LOAD/W_FULL, R_IDLE/R_RUN encodings.
//  One sub-module, wb_bank_ram: 2 x BUFFER_DEPTH x DATA_WIDTH register file.
//   1 synchronous write port (bank, addr), 1 asynchronous read port.
//  Top level holds both FSMs, pointers, size latches, swap logic.
// TESTING
//  1 Reset, load 9 beats (1..9), size=9 -> load_done pulses once; un_configed 1->0.
//    rd_start, repeat=2 -> 18 valid words 1..9,1..9; out_last only on the 18th.
//  2 Stream kernel A (repeat=3) while loading B -> A is output intact.
//    load_done for B comes on the cycle after A's out_last. Next stream outputs B.
//  3 rd_start before any load -> out_valid stays 0.
//    Then load + rd_start in the swap cycle -> new kernel streamed.
//  4 kernel_size=0 -> 1 beat accepted; kernel_size=40 -> 16 beats accepted.
//    cfg_err=1 in both cases. wr_ready drops exactly after the last beat.
//  5 rd_stall for 3 cycles mid-stream -> out_valid=0, rd_ptr held.
//    Sequence resumes with no skipped or duplicated words. wr_valid gaps during load are tolerated.
//  6 rst mid-load and mid-stream -> all outputs at reset values next cycle; un_configed=1.

Source files
------------

// File: rtl/weight_pingpong_buff_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : weight_pingpong_buff_pkg
//  Purpose : Shared widths and FSM state encodings for the ping-pong weight
//            buffer (write/load FSM and read/stream FSM).
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package weight_pingpong_buff_pkg;

    localparam int KSIZE_W = 8;   // kernel_size port width
    localparam int PASS_W  = 8;   // rd_repeat / pass counter width

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_LOAD = 2'd1,
        W_FULL = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RUN  = 1'b1
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/weight_pingpong_buff_if.sv
`default_nettype none
// ============================================================================
//  Module  : weight_pingpong_buff_if
//  Purpose : Load-side and read-side signal bundle of the ping-pong buffer.
//  Ports   : master = loader/PE controller side, slave = buffer side.
//            kernel_size, load_start, wr_valid, wr_data, rd_start, rd_repeat,
//            rd_stall flow master->slave; the status/stream signals flow back.
//  Rev     : 1.0  initial release
// ============================================================================
interface weight_pingpong_buff_if #(
    parameter int DATA_WIDTH = 16
);
    import weight_pingpong_buff_pkg::*;

    logic [KSIZE_W-1:0]    kernel_size;
    logic                  load_start;
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  load_done;
    logic                  cfg_err;
    logic                  kernel_busy;
    logic                  un_configed;
    logic                  rd_start;
    logic [PASS_W-1:0]     rd_repeat;
    logic                  rd_stall;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  out_valid;
    logic                  out_last;
    logic                  read_busy;

    modport master (
        output kernel_size, load_start, wr_valid, wr_data,
               rd_start, rd_repeat, rd_stall,
        input  wr_ready, load_done, cfg_err, kernel_busy, un_configed,
               data_out, out_valid, out_last, read_busy
    );

    modport slave (
        input  kernel_size, load_start, wr_valid, wr_data,
               rd_start, rd_repeat, rd_stall,
        output wr_ready, load_done, cfg_err, kernel_busy, un_configed,
               data_out, out_valid, out_last, read_busy
    );
endinterface
`default_nettype wire

// File: rtl/weight_pingpong_buff_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module  : wb_bank_ram
//  Purpose : 2 x BUFFER_DEPTH x DATA_WIDTH register file holding both banks.
//            One synchronous write port, one asynchronous read port.
//  Ports   : clk, we_i, wr_bank_i, wr_addr_i, wr_data_i (write)
//            rd_bank_i, rd_addr_i -> rd_data_o (combinational read)
//  Rev     : 1.0  initial release
// ============================================================================
module wb_bank_ram #(
    parameter int DATA_WIDTH   = 16,
    parameter int BUFFER_DEPTH = 16
) (
    input  wire logic                            clk,
    input  wire logic                            we_i,
    input  wire logic                            wr_bank_i,
    input  wire logic [$clog2(BUFFER_DEPTH)-1:0] wr_addr_i,
    input  wire logic [DATA_WIDTH-1:0]           wr_data_i,
    input  wire logic                            rd_bank_i,
    input  wire logic [$clog2(BUFFER_DEPTH)-1:0] rd_addr_i,
    output logic      [DATA_WIDTH-1:0]           rd_data_o
);
    // Contents are intentionally not reset.
    logic [DATA_WIDTH-1:0] mem_q [2][BUFFER_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_bank_i][rd_addr_i];
endmodule
`default_nettype wire

// File: rtl/weight_pingpong_buff.sv
`default_nettype none
// ============================================================================
//  Module  : weight_pingpong_buff
//  Purpose : Double-banked weight buffer. A kernel loads into the shadow bank
//            while the active bank streams to the PEs, optionally repeated.
//            The bank swap waits until the reader is idle.
//  Ports   : clk, rst (sync, active-high)
//            bus (slave): load side kernel_size/load_start/wr_* with
//            wr_ready/load_done/cfg_err/kernel_busy/un_configed; read side
//            rd_start/rd_repeat/rd_stall with data_out/out_valid/out_last/
//            read_busy.
//  Rev     : 1.0  initial release
// ============================================================================
module weight_pingpong_buff
    import weight_pingpong_buff_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int BUFFER_DEPTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    weight_pingpong_buff_if.slave bus
);
    localparam int PTR_W  = $clog2(BUFFER_DEPTH);
    localparam int SIZE_W = PTR_W + 1;
    localparam logic [SIZE_W-1:0] DEPTH_SZ = SIZE_W'(BUFFER_DEPTH);

    wr_state_e           wr_state_q;
    rd_state_e           rd_state_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [SIZE_W-1:0]   shadow_size_q;
    logic [SIZE_W-1:0]   active_size_q;
    logic                active_bank_q;
    logic                un_configed_q;
    logic                cfg_err_q;
    logic [PASS_W-1:0]   rd_repeat_q;
    logic [PASS_W-1:0]   pass_cnt_q;

    logic                  beat;
    logic                  swap;
    logic                  rd_go;
    logic                  wr_last;
    logic                  rd_wrap;
    logic                  pass_last;
    logic                  size_zero;
    logic                  size_over;
    logic [SIZE_W-1:0]     size_d;
    logic [PASS_W-1:0]     repeat_d;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    assign beat      = (wr_state_q == W_LOAD) && bus.wr_valid;
    // The swap commits only when the reader is idle, so a stream never sees
    // its bank change underneath it.
    assign swap      = (wr_state_q == W_FULL) && (rd_state_q == R_IDLE);
    // A start coinciding with the swap is accepted and streams the new bank.
    assign rd_go     = (rd_state_q == R_IDLE) && bus.rd_start && (!un_configed_q || swap);
    assign wr_last   = {1'b0, wr_ptr_q} == (shadow_size_q - SIZE_W'(1));
    assign rd_wrap   = {1'b0, rd_ptr_q} == (active_size_q - SIZE_W'(1));
    assign pass_last = pass_cnt_q == (rd_repeat_q - PASS_W'(1));

    assign size_zero = bus.kernel_size == '0;
    assign size_over = {1'b0, bus.kernel_size} > (KSIZE_W+1)'(BUFFER_DEPTH);

    always_comb begin
        size_d = SIZE_W'(bus.kernel_size);
        if (size_zero) begin
            size_d = SIZE_W'(1);
        end else if (size_over) begin
            size_d = DEPTH_SZ;
        end
    end

    assign repeat_d = (bus.rd_repeat == '0) ? PASS_W'(1) : bus.rd_repeat;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q    <= W_IDLE;
            rd_state_q    <= R_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            shadow_size_q <= '0;
            active_size_q <= '0;
            active_bank_q <= 1'b0;
            un_configed_q <= 1'b1;
            cfg_err_q     <= 1'b0;
            rd_repeat_q   <= '0;
            pass_cnt_q    <= '0;
        end else begin
            // ---------------- write / load FSM ----------------
            case (wr_state_q)
                W_IDLE: begin
                    if (bus.load_start) begin
                        wr_state_q    <= W_LOAD;
                        wr_ptr_q      <= '0;
                        shadow_size_q <= size_d;
                        cfg_err_q     <= size_zero || size_over;
                    end
                end
                W_LOAD: begin
                    if (beat) begin
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        if (wr_last) begin
                            wr_state_q <= W_FULL;
                        end
                    end
                end
                W_FULL: begin
                    if (swap) begin
                        active_bank_q <= ~active_bank_q;
                        active_size_q <= shadow_size_q;
                        un_configed_q <= 1'b0;
                        wr_state_q    <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase

            // ---------------- read / stream FSM ----------------
            case (rd_state_q)
                R_IDLE: begin
                    if (rd_go) begin
                        rd_state_q  <= R_RUN;
                        rd_ptr_q    <= '0;
                        pass_cnt_q  <= '0;
                        rd_repeat_q <= repeat_d;
                    end
                end
                R_RUN: begin
                    if (!bus.rd_stall) begin
                        if (rd_wrap) begin
                            rd_ptr_q   <= '0;
                            pass_cnt_q <= pass_cnt_q + PASS_W'(1);
                            if (pass_last) begin
                                rd_state_q <= R_IDLE;
                            end
                        end else begin
                            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    // Writes always go to the shadow bank, never the one being streamed.
    wb_bank_ram #(
        .DATA_WIDTH   (DATA_WIDTH),
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_ram (
        .clk       (clk),
        .we_i      (beat),
        .wr_bank_i (~active_bank_q),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.wr_data),
        .rd_bank_i (active_bank_q),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_data)
    );

    assign bus.wr_ready    = (wr_state_q == W_LOAD);
    assign bus.load_done   = swap;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.kernel_busy = (wr_state_q != W_IDLE);
    assign bus.un_configed = un_configed_q;
    assign bus.read_busy   = (rd_state_q == R_RUN);
    assign bus.out_valid   = (rd_state_q == R_RUN) && !bus.rd_stall;
    assign bus.out_last    = bus.out_valid && rd_wrap && pass_last;
    assign bus.data_out    = bus.out_valid ? ram_rd_data : '0;
endmodule
`default_nettype wire

// File: tb/tb_weight_pingpong_buff.sv
`default_nettype none
// ============================================================================
//  Module  : tb_weight_pingpong_buff
//  Purpose : Directed self-checking bench for weight_pingpong_buff.
//            Inputs change on the falling edge; outputs are sampled just after.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_weight_pingpong_buff;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_cyc = -1;
    logic [15:0] got[$];
    logic        lasts[$];

    weight_pingpong_buff_if #(.DATA_WIDTH(16)) bus();

    weight_pingpong_buff #(
        .DATA_WIDTH   (16),
        .BUFFER_DEPTH (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stream / swap monitor, sampled mid-cycle after the inputs settle.
    always @(negedge clk) begin
        #2;
        if (bus.out_valid) begin
            got.push_back(bus.data_out);
            lasts.push_back(bus.out_last);
        end
        if (bus.out_last) last_cyc = cyc;
        if (bus.load_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] flags();
        return {bus.wr_ready, bus.load_done, bus.cfg_err, bus.kernel_busy,
                bus.un_configed, bus.out_valid, bus.out_last, bus.read_busy};
    endfunction

    // Number of differences between captured stream and base..base+len-1 x rep.
    function automatic int seq_errs(input int base, input int len, input int rep);
        int n = 0;
        if (got.size() != len * rep) n++;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== 16'(base + (i % len))) n++;
        return n;
    endfunction

    // Index of the single out_last word; -1 none, -2 more than one.
    function automatic int last_pos();
        int p = -1;
        for (int i = 0; i < lasts.size(); i++)
            if (lasts[i]) p = (p == -1) ? i : -2;
        return p;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_capture();
        got.delete();
        lasts.delete();
    endtask

    // Starts a load and offers nbeats beats; returns beats seen with wr_ready.
    // Returns on the falling edge after the final offered beat.
    task automatic load(input int ksize, input int nbeats, input int base,
                        input bit gap, output int accepted);
        accepted = 0;
        @(negedge clk);
        bus.load_start  = 1'b1;
        bus.kernel_size = 8'(ksize);
        @(negedge clk);
        bus.load_start = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (gap && i == 3) begin
                bus.wr_valid = 1'b0;
                @(negedge clk);
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = 16'(base + i);
            #1;
            if (bus.wr_ready) accepted++;
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic start_read(input int rep);
        @(negedge clk);
        bus.rd_start  = 1'b1;
        bus.rd_repeat = 8'(rep);
        @(negedge clk);
        bus.rd_start = 1'b0;
    endtask

    task automatic wait_idle(output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (!bus.read_busy) begin
                timeout = 1'b0;
                break;
            end
        end
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (flags() !== 8'b0000_1000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected %b", flags(), 8'b0000_1000);
        end
        checks++;
        if (bus.data_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: got %0d expected 0", bus.data_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_repeat();
        int acc;
        int d0;
        bit to;
        d0 = done_cnt;
        load(9, 9, 1, 1'b0, acc);
        idle(3);
        checks++;
        if (acc !== 9) begin errors++; $display("FAIL t1_beats: got %0d expected 9", acc); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL t1_load_done: got %0d pulses expected 1", done_cnt - d0); end
        checks++;
        if (bus.un_configed !== 1'b0) begin errors++; $display("FAIL t1_unconfiged: got %b expected 0", bus.un_configed); end
        clear_capture();
        start_read(2);
        wait_idle(to);
        checks++;
        if (to || seq_errs(1, 9, 2) !== 0) begin
            errors++;
            $display("FAIL t1_stream: %0d words, %0d errors, timeout %0d expected 18 words 0 errors", got.size(), seq_errs(1, 9, 2), to);
        end
        checks++;
        if (last_pos() !== 17) begin errors++; $display("FAIL t1_last: got index %0d expected 17", last_pos()); end
    endtask

    task automatic test_concurrent_load();
        int acc;
        int d0;
        bit to;
        logic kb;
        d0 = done_cnt;
        clear_capture();
        start_read(3);
        load(4, 4, 100, 1'b0, acc);
        #1;
        kb = bus.kernel_busy;
        wait_idle(to);
        checks++;
        if (to || seq_errs(1, 9, 3) !== 0) begin
            errors++;
            $display("FAIL t2_streamA: %0d words, %0d errors, timeout %0d expected 27 words 0 errors", got.size(), seq_errs(1, 9, 3), to);
        end
        checks++;
        if (kb !== 1'b1) begin errors++; $display("FAIL t2_busy: got %b expected 1", kb); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL t2_load_done: got %0d pulses expected 1", done_cnt - d0); end
        checks++;
        if (done_cyc !== last_cyc + 1) begin errors++; $display("FAIL t2_swap_cycle: got %0d expected %0d", done_cyc, last_cyc + 1); end
        clear_capture();
        start_read(1);
        wait_idle(to);
        checks++;
        if (to || seq_errs(100, 4, 1) !== 0) begin
            errors++;
            $display("FAIL t2_streamB: %0d words, %0d errors, timeout %0d expected 4 words 0 errors", got.size(), seq_errs(100, 4, 1), to);
        end
    endtask

    task automatic test_unconfigured_start();
        int acc;
        bit to;
        logic ld;
        do_reset();
        clear_capture();
        start_read(1);
        idle(5);
        #1;
        checks++;
        if (got.size() !== 0 || bus.read_busy !== 1'b0) begin
            errors++;
            $display("FAIL t3_no_stream: got %0d words busy %b expected 0 words busy 0", got.size(), bus.read_busy);
        end
        load(3, 3, 50, 1'b0, acc);
        bus.rd_start  = 1'b1;
        bus.rd_repeat = 8'd0;
        #1;
        ld = bus.load_done;
        @(negedge clk);
        bus.rd_start = 1'b0;
        wait_idle(to);
        checks++;
        if (ld !== 1'b1) begin errors++; $display("FAIL t3_swap_cycle: load_done got %b expected 1", ld); end
        checks++;
        if (to || seq_errs(50, 3, 1) !== 0) begin
            errors++;
            $display("FAIL t3_stream: %0d words, %0d errors, timeout %0d expected 3 words 0 errors", got.size(), seq_errs(50, 3, 1), to);
        end
        checks++;
        if (last_pos() !== 2) begin errors++; $display("FAIL t3_last: got index %0d expected 2", last_pos()); end
    endtask

    task automatic test_size_clamp();
        int acc;
        bit to;
        load(0, 3, 7, 1'b0, acc);
        #1;
        checks++;
        if (acc !== 1 || bus.cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL t4_size0: beats %0d cfg_err %b expected 1 beat cfg_err 1", acc, bus.cfg_err);
        end
        idle(2);
        clear_capture();
        start_read(1);
        wait_idle(to);
        checks++;
        if (to || seq_errs(7, 1, 1) !== 0) begin
            errors++;
            $display("FAIL t4_stream0: %0d words, %0d errors expected 1 word 0 errors", got.size(), seq_errs(7, 1, 1));
        end
        load(40, 20, 200, 1'b0, acc);
        #1;
        checks++;
        if (acc !== 16) begin errors++; $display("FAIL t4_size40: got %0d beats expected 16", acc); end
        checks++;
        if (bus.wr_ready !== 1'b0 || bus.cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL t4_flags: wr_ready %b cfg_err %b expected 0 1", bus.wr_ready, bus.cfg_err);
        end
        idle(2);
        clear_capture();
        start_read(1);
        wait_idle(to);
        checks++;
        if (to || seq_errs(200, 16, 1) !== 0) begin
            errors++;
            $display("FAIL t4_stream40: %0d words, %0d errors expected 16 words 0 errors", got.size(), seq_errs(200, 16, 1));
        end
    endtask

    task automatic test_stall();
        int acc;
        int bad;
        bit to;
        load(5, 5, 300, 1'b1, acc);
        checks++;
        if (acc !== 5) begin errors++; $display("FAIL t5_gap_beats: got %0d expected 5", acc); end
        idle(2);
        clear_capture();
        start_read(1);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.rd_stall = 1'b1;
            #1;
            if (bus.out_valid !== 1'b0 || bus.data_out !== 16'd0) bad++;
        end
        @(negedge clk);
        bus.rd_stall = 1'b0;
        #1;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL t5_stall_out: got %0d bad stall cycles expected 0", bad); end
        checks++;
        if (bus.data_out !== 16'd302) begin errors++; $display("FAIL t5_resume: got %0d expected 302", bus.data_out); end
        wait_idle(to);
        checks++;
        if (to || seq_errs(300, 5, 1) !== 0) begin
            errors++;
            $display("FAIL t5_stream: %0d words, %0d errors expected 5 words 0 errors", got.size(), seq_errs(300, 5, 1));
        end
    endtask

    task automatic test_reset_midop();
        int acc;
        logic kb;
        load(8, 3, 400, 1'b0, acc);
        #1;
        kb = bus.kernel_busy;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (kb !== 1'b1 || flags() !== 8'b0000_1000) begin
            errors++;
            $display("FAIL t6_midload: busy_before %b flags %b expected 1 00001000", kb, flags());
        end
        rst = 1'b0;
        load(4, 4, 500, 1'b0, acc);
        idle(2);
        start_read(5);
        idle(3);
        #1;
        kb = bus.read_busy;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (kb !== 1'b1 || flags() !== 8'b0000_1000 || bus.data_out !== 16'd0) begin
            errors++;
            $display("FAIL t6_midstream: busy_before %b flags %b data %0d expected 1 00001000 0", kb, flags(), bus.data_out);
        end
        rst = 1'b0;
        idle(2);
    endtask

    initial begin
        bus.kernel_size = '0;
        bus.load_start  = 1'b0;
        bus.wr_valid    = 1'b0;
        bus.wr_data     = '0;
        bus.rd_start    = 1'b0;
        bus.rd_repeat   = '0;
        bus.rd_stall    = 1'b0;

        test_reset();
        test_load_repeat();
        test_concurrent_load();
        test_unconfigured_start();
        test_size_clamp();
        test_stall();
        test_reset_midop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
